// File: rtl/jogo_pkg.sv
// Shared encodings for the ultimate tic-tac-toe judge: cell/macro states, judge FSM states,
// winning-line masks and the verdict helper.
package jogo_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY   = 2'b00,
      CELL_P1      = 2'b01,
      CELL_P2      = 2'b10,
      CELL_NEUTRAL = 2'b11
   } cell_e;

   typedef enum logic [1:0] {
      MACRO_PENDING = 2'b00,
      MACRO_P1_WON  = 2'b01,
      MACRO_P2_WON  = 2'b10,
      MACRO_DRAW    = 2'b11
   } macro_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_EVAL  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned NUM_LINES = 8;
   localparam logic [3:0]  ADDR_FIRST = 4'd1;
   localparam logic [3:0]  ADDR_LAST  = 4'd9;

   // Bit k-1 of each mask selects micro cell k (row-major, cell 1 top-left).
   localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] LINE_MASKS = {
      9'b000_000_111,
      9'b000_111_000,
      9'b111_000_000,
      9'b001_001_001,
      9'b010_010_010,
      9'b100_100_100,
      9'b100_010_001,
      9'b001_010_100
   };

   function automatic macro_e judge(input logic p1_line, input logic p2_line, input logic full);
      if (p1_line && p2_line) return MACRO_DRAW;
      if (p1_line)            return MACRO_P1_WON;
      if (p2_line)            return MACRO_P2_WON;
      if (full)               return MACRO_DRAW;
      return MACRO_PENDING;
   endfunction

endpackage

// File: rtl/macro_cell_judge_line_checker.sv
// Combinational scan of a 3x3 micro board: flags a complete line per player and a fully
// occupied board.
module line_checker
   import jogo_pkg::*;
(
   input  logic [NUM_CELLS-1:0][1:0] cells,
   output logic                      p1_line,
   output logic                      p2_line,
   output logic                      full
);

   logic [NUM_CELLS-1:0] w_is_p1;
   logic [NUM_CELLS-1:0] w_is_p2;

   always_comb begin
      w_is_p1 = '0;
      w_is_p2 = '0;
      full    = 1'b1;
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
         w_is_p1[k] = (cells[k] == CELL_P1);
         w_is_p2[k] = (cells[k] == CELL_P2);
         if (cells[k] == CELL_EMPTY) full = 1'b0;
      end
   end

   always_comb begin
      p1_line = 1'b0;
      p2_line = 1'b0;
      for (int unsigned l = 0; l < NUM_LINES; l++) begin
         if ((w_is_p1 & LINE_MASKS[l]) == LINE_MASKS[l]) p1_line = 1'b1;
         if ((w_is_p2 & LINE_MASKS[l]) == LINE_MASKS[l]) p2_line = 1'b1;
      end
   end

endmodule

// File: rtl/macro_cell_judge.sv
// Reads a 9-cell micro board, judges it and writes the verdict to the macro board RAM.
// Optional JUDGE_SKIP_PENDING_EN: skip the WRITE state when the board is still in progress.
module macro_cell_judge
   import jogo_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [3:0] macro_addr,
   output logic [3:0] micro_addr,
   input  logic [1:0] micro_data,
   output logic       we,
   output logic [3:0] addr,
   output logic [1:0] data,
   output logic       busy,
   output logic       done,
   output logic [1:0] result
);

   state_e                   r_state;
   state_e                   w_next;
   logic [3:0]               r_cnt;
   logic [3:0]               r_pend;
   logic [3:0]               r_maddr;
   logic [NUM_CELLS-1:0][1:0] r_cells;
   logic [1:0]               r_result;
   logic                     w_p1;
   logic                     w_p2;
   logic                     w_full;
   macro_e                   w_verdict;
   logic                     w_addr_ok;

   line_checker u_line_checker (
      .cells   (r_cells),
      .p1_line (w_p1),
      .p2_line (w_p2),
      .full    (w_full)
   );

   assign w_verdict = judge(w_p1, w_p2, w_full);
   assign w_addr_ok = (r_maddr >= ADDR_FIRST) && (r_maddr <= ADDR_LAST);
   assign result    = r_result;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_next = ST_READ;
         ST_READ:  if (r_cnt == ADDR_LAST) w_next = ST_DRAIN;
         ST_DRAIN: w_next = ST_EVAL;
`ifdef JUDGE_SKIP_PENDING_EN
         ST_EVAL:  w_next = (w_verdict == MACRO_PENDING) ? ST_DONE : ST_WRITE;
`else
         ST_EVAL:  w_next = ST_WRITE;
`endif
         ST_WRITE: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      micro_addr = '0;
      we         = 1'b0;
      addr       = '0;
      data       = '0;
      busy       = (r_state != ST_IDLE);
      done       = (r_state == ST_DONE);
      if (r_state == ST_READ) micro_addr = r_cnt;
      if (r_state == ST_WRITE) begin
         we   = w_addr_ok;
         addr = r_maddr;
         data = r_result;
      end
   end

   // r_pend holds the address presented last cycle; its RAM data is on micro_data now.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_pend   <= '0;
         r_maddr  <= '0;
         r_cells  <= '0;
         r_result <= '0;
      end else begin
         r_pend <= micro_addr;
         for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            if (r_pend == 4'(k + 1)) r_cells[k] <= micro_data;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_maddr <= macro_addr;
                  r_cnt   <= ADDR_FIRST;
               end
            end
            ST_READ: r_cnt <= (r_cnt == ADDR_LAST) ? '0 : r_cnt + 4'd1;
            ST_EVAL: r_result <= w_verdict;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_macro_cell_judge.sv
// Directed bench for macro_cell_judge: a job-timeline model checked every cycle plus
// hand-computed per-job expectations.
module tb_macro_cell_judge;

`ifdef JUDGE_SKIP_PENDING_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [3:0] macro_addr;
   logic [3:0] micro_addr;
   logic [1:0] micro_data;
   logic       we;
   logic [3:0] addr;
   logic [1:0] data;
   logic       busy;
   logic       done;
   logic [1:0] result;

   int n_checks = 0;
   int n_err    = 0;

   logic [1:0] mem [0:15];
   int LN [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                     '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

   int         m_cyc  = 0;
   int         m_len  = 13;
   logic [3:0] m_maddr = '0;
   logic [1:0] m_res  = '0;
   logic [1:0] m_jres = '0;

   macro_cell_judge dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .macro_addr (macro_addr),
      .micro_addr (micro_addr),
      .micro_data (micro_data),
      .we         (we),
      .addr       (addr),
      .data       (data),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   // Synchronous micro-board RAM: data follows the address by one cycle.
   always @(posedge clk) micro_data <= mem[micro_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] judge_board();
      logic w1, w2, full;
      w1 = 1'b0; w2 = 1'b0; full = 1'b1;
      for (int l = 0; l < 8; l++) begin
         if (mem[LN[l][0]] == 2'b01 && mem[LN[l][1]] == 2'b01 && mem[LN[l][2]] == 2'b01) w1 = 1'b1;
         if (mem[LN[l][0]] == 2'b10 && mem[LN[l][1]] == 2'b10 && mem[LN[l][2]] == 2'b10) w2 = 1'b1;
      end
      for (int c = 1; c <= 9; c++) if (mem[c] == 2'b00) full = 1'b0;
      if (w1 && w2) return 2'b11;
      if (w1)       return 2'b01;
      if (w2)       return 2'b10;
      if (full)     return 2'b11;
      return 2'b00;
   endfunction

   // Job timeline: m_cyc = 1 in the cycle after the start-sampling edge, 0 when idle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cyc   <= 0;
         m_len   <= 13;
         m_maddr <= '0;
         m_res   <= '0;
         m_jres  <= '0;
      end else if (m_cyc == 0) begin
         if (start) begin
            m_cyc   <= 1;
            m_maddr <= macro_addr;
            m_jres  <= judge_board();
            m_len   <= (SKIP && judge_board() == 2'b00) ? 12 : 13;
         end
      end else begin
         if (m_cyc == 11) m_res <= m_jres;
         m_cyc <= (m_cyc == m_len) ? 0 : m_cyc + 1;
      end
   end

   logic       e_wcyc, e_vld;
   logic [3:0] e_ma;
   always @(negedge clk) begin
      e_wcyc = (m_cyc == 12) && (m_len == 13);
      e_vld  = (m_maddr >= 4'd1) && (m_maddr <= 4'd9);
      e_ma   = (m_cyc >= 1 && m_cyc <= 9) ? m_cyc[3:0] : 4'd0;
      chk("cyc_busy", busy, (m_cyc != 0));
      chk("cyc_micro_addr", micro_addr, e_ma);
      chk("cyc_we", we, e_wcyc && e_vld);
      chk("cyc_done", done, (m_cyc != 0) && (m_cyc == m_len));
      chk("cyc_result", result, m_res);
      if (!e_wcyc) begin
         chk("cyc_addr_idle", addr, 0);
         chk("cyc_data_idle", data, 0);
      end else if (e_vld) begin
         chk("cyc_addr_wr", addr, m_maddr);
         chk("cyc_data_wr", data, m_res);
      end
   end

   task automatic load_board(input logic [17:0] b);
      for (int k = 1; k <= 9; k++) mem[k] = b[(9-k)*2 +: 2];
   endtask

   task automatic run_job(input string nm, input logic [17:0] b, input logic [3:0] ma,
                          input logic [1:0] exp_res, input int restart_at);
      int nwe, wk, dk, exp_dk, exp_nwe;
      logic [3:0] wa;
      logic [1:0] wd;
      nwe = 0; wk = 0; dk = 0; wa = '0; wd = '0;
      exp_dk  = (SKIP && exp_res == 2'b00) ? 12 : 13;
      exp_nwe = ((ma >= 4'd1) && (ma <= 4'd9) && exp_dk == 13) ? 1 : 0;
      @(negedge clk);
      load_board(b);
      macro_addr = ma;
      start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (we) begin
            nwe++; wk = k; wa = addr; wd = data;
         end
         if (done) begin
            dk = k;
            break;
         end
      end
      if (start) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk({nm, " we_count"}, nwe, exp_nwe);
      if (exp_nwe == 1) begin
         chk({nm, " we_cycle"}, wk, 12);
         chk({nm, " we_addr"}, wa, ma);
         chk({nm, " we_data"}, wd, exp_res);
      end
      chk({nm, " done_cycle"}, dk, exp_dk);
      chk({nm, " result"}, result, exp_res);
   endtask

   initial begin
      int nwe, nbusy;
      reset_n = 1'b0;
      start = 1'b0;
      macro_addr = '0;
      for (int i = 0; i < 16; i++) mem[i] = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst we", we, 0);
      chk("rst done", done, 0);
      chk("rst micro_addr", micro_addr, 0);
      chk("rst result", result, 0);
      #2 reset_n = 1'b1;

      run_job("p1_row",     18'b01_01_01_00_00_00_00_00_00, 4'd5,  2'b01, 0);
      run_job("p2_diag",    18'b01_01_10_00_10_01_10_00_00, 4'd9,  2'b10, 0);
      run_job("draw",       18'b01_10_01_01_10_10_10_01_01, 4'd2,  2'b11, 0);
      run_job("both",       18'b01_01_01_00_00_00_10_10_10, 4'd1,  2'b11, 0);
      run_job("neutral",    18'b11_11_11_11_11_11_11_11_11, 4'd7,  2'b11, 0);
      run_job("p2_col",     18'b10_00_00_10_00_00_10_01_01, 4'd3,  2'b10, 0);
      run_job("empty",      18'b00_00_00_00_00_00_00_00_00, 4'd4,  2'b00, 0);
      run_job("addr0",      18'b00_00_00_00_00_00_00_00_00, 4'd0,  2'b00, 0);
      run_job("addr10",     18'b01_01_01_00_00_00_00_00_00, 4'd10, 2'b01, 0);
      run_job("addr15",     18'b01_00_00_00_01_00_00_00_01, 4'd15, 2'b01, 0);
      run_job("restart5",   18'b01_01_01_00_00_00_00_00_00, 4'd6,  2'b01, 5);
      run_job("restart_dn", 18'b00_10_00_00_10_00_00_10_00, 4'd8,  2'b10, 13);

      // Reset mid-job: previous result is 10, so a cleared result is observable.
      @(negedge clk);
      load_board(18'b01_01_01_00_00_00_00_00_00);
      macro_addr = 4'd3;
      start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("midrst busy", busy, 0);
      chk("midrst we", we, 0);
      chk("midrst done", done, 0);
      chk("midrst micro_addr", micro_addr, 0);
      chk("midrst addr", addr, 0);
      chk("midrst data", data, 0);
      chk("midrst result", result, 0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      nwe = 0; nbusy = 0;
      repeat (20) begin
         @(negedge clk);
         if (we) nwe++;
         if (busy) nbusy++;
      end
      chk("post_rst we_count", nwe, 0);
      chk("post_rst busy_count", nbusy, 0);

      run_job("after_rst",  18'b01_01_10_00_10_01_10_00_00, 4'd1,  2'b10, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/macro_cell_judge.md
MACRO_CELL_JUDGE -- requirements
Module: macro_cell_judge

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to judge one micro board; sampled only in IDLE.
REQ-004 SHALL have port macro_addr, input, 4 bits: target macro cell (1..9); latched with start.
REQ-005 SHALL have port micro_addr, output, 4 bits: read address into the micro-board RAM (1..9).
REQ-006 SHALL have port micro_data, input, 2 bits: micro-cell contents, valid one cycle after micro_addr is presented (00 empty, 01 player 1, 10 player 2, 11 occupied/neutral).
REQ-007 SHALL have port we, output, 1 bit: write strobe toward the macro board-state RAM.
REQ-008 SHALL have port addr, output, 4 bits: macro board-state RAM write address.
REQ-009 SHALL have port data, output, 2 bits: macro cell state written (00 in progress, 01 P1 won, 10 P2 won, 11 draw).
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking job completion.
REQ-012 SHALL have port result, output, 2 bits: last computed micro-board state; held until the next job's EVAL.

Function
REQ-013 SHALL implement FSM states IDLE, READ, DRAIN, EVAL, WRITE, DONE.
REQ-014 SHALL, in IDLE with start=1, latch macro_addr, set read counter to 1 and enter READ.
REQ-015 SHALL, in READ, drive micro_addr = counter, increment counter 1..9 each cycle, and enter DRAIN after address 9.
REQ-016 SHALL capture micro_data into cell register k on the edge following presentation of address k; the cell-9 capture occurs in DRAIN.
REQ-017 SHALL, in EVAL, register result from the nine captured cells.
REQ-018 SHALL set result to 01 when any of the 8 lines (3 rows, 3 columns, 2 diagonals) is all 01.
REQ-019 SHALL set result to 10 when any line is all 10.
REQ-020 SHALL set result to 11 when lines for both players exist.
REQ-021 SHALL set result to 11 when there is no winning line and all nine cells are nonzero.
REQ-022 SHALL set result to 00 in all other cases.
REQ-023 SHALL, in WRITE, assert we for exactly one cycle with addr = latched macro_addr and data = result.
REQ-024 SHALL then pass through DONE, where done=1, and return to IDLE.
REQ-025 SHALL assert we in the cycle after the 11th rising edge following the edge that samples start, and assert done in the following cycle; total occupancy is 13 cycles.
REQ-026 SHALL ignore start while busy=1; a start asserted in DONE's cycle is not sampled.
REQ-027 SHALL, when latched macro_addr is 0 or greater than 9, run the full sequence with we held 0 in WRITE; done still pulses.
REQ-028 SHALL drive we, addr and data as 0 outside WRITE, and micro_addr as 0 outside READ.

Reset
REQ-029 SHALL, while reset_n=0 (asserted at any time, including mid-job), force state IDLE and zero counter, cell registers, latched address, result, we, addr, data, micro_addr, busy and done.
REQ-030 SHALL NOT issue a write for a job interrupted by reset.

Configuration
REQ-031 SHALL, when JUDGE_SKIP_PENDING_EN is defined, go directly from EVAL to DONE with no we pulse when result=00, so done is asserted one cycle earlier than in REQ-025.
REQ-032 SHALL, when JUDGE_SKIP_PENDING_EN is undefined, always traverse WRITE, including writes of 00.

Structure
REQ-033 SHALL take the cell/macro state encodings (00/01/10/11) and FSM state encodings from the shared package jogo_pkg.
REQ-034 SHALL instantiate one sub-module, line_checker: purely combinational, nine 2-bit cells in, p1_line/p2_line/full out; used by EVAL.

Verification
REQ-035 SHALL verify a P1 win: micro row 1,2,3 = 01, rest 00, macro_addr=5 -> single we pulse with addr=5, data=01 at cycle 12; done at cycle 13.
REQ-036 SHALL verify a P2 diagonal: cells 3,5,7 = 10, others mixed without a line, macro_addr=9 -> data=10 written to addr 9.
REQ-037 SHALL verify a draw: cells 01,10,01,01,10,10,10,01,01 (no line), macro_addr=2 -> data=11 written.
REQ-038 SHALL verify in-progress and invalid-address behaviour with the macro undefined: empty board, macro_addr=4 -> data=00 written; macro_addr=0 -> no we, done pulses; with the macro defined, empty board -> no we, done at cycle 12.
REQ-039 SHALL verify busy and reset behaviour: start re-asserted at cycle 5 -> ignored, exactly one write; reset_n low at cycle 7 -> immediate IDLE, all outputs 0, no we thereafter.
